// File: rtl/bin_to_xs3_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential binary-to-BCD/excess-3 converter.
package bin_to_xs3_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_BIAS   = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // 10^n, wide enough for the largest legal digit count (10^10 needs 34 bits).
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_xs3_seq_adj.sv
// Single-digit double-dabble correction: add 3 when the BCD digit is 5 or more.
module xs3_digit_adj
  import bin_to_xs3_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj_c
);

  assign adj_c = (digit >= ADJ_THRESH) ? digit + XS3_BIAS : digit;

endmodule

// File: rtl/bin_to_xs3_seq.sv
// Sequential binary to BCD / excess-3 converter, one shift-add-3 iteration per clock.
// Optional out_par (even parity of dout) when BIN_TO_XS3_SEQ_PARITY_EN is defined.
module bin_to_xs3_seq
  import bin_to_xs3_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  mode_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  ovf,
  output logic                  busy
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
  , output logic                out_par
`endif
);

  localparam int unsigned DOUT_W    = 4 * DIGITS;
  localparam int unsigned CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  state_t              state, state_n;
  logic [BIN_W-1:0]    shift, shift_n;
  logic [DOUT_W-1:0]   digits, digits_n, adj_c, dout_n;
  logic [CNT_W-1:0]    count, count_n;
  logic                mode, mode_n, ovf_n;
  logic                in_ready_n, out_valid_n, busy_n;

  // Saturate on overflow, then optionally bias every digit into excess-3.
  function automatic logic [DOUT_W-1:0] finalize(input logic [DOUT_W-1:0] bcd,
                                                 input logic sat, input logic xs3);
    logic [DOUT_W-1:0] r;
    logic [3:0]        d;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = sat ? 4'd9 : bcd[4*i +: 4];
      if (xs3) d = d + XS3_BIAS;
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    xs3_digit_adj u_adj (
      .digit (digits[4*g +: 4]),
      .adj_c (adj_c[4*g +: 4])
    );
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    digits_n = digits;
    count_n  = count;
    mode_n   = mode;
    dout_n   = dout;
    ovf_n    = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          shift_n  = bin_in;
          mode_n   = mode_xs3;
          digits_n = '0;
          count_n  = CNT_W'(BIN_W);
          ovf_n    = (64'(bin_in) >= OVF_LIMIT);
          state_n  = CONV;
        end
      end
      CONV: begin
        // Bits shifted out of the top digit only matter on overflow, which saturates anyway.
        digits_n = DOUT_W'({adj_c, shift[BIN_W-1]});
        shift_n  = {shift[BIN_W-2:0], 1'b0};
        count_n  = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          dout_n  = finalize(digits_n, ovf, mode);
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      digits    <= '0;
      count     <= '0;
      mode      <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      digits    <= digits_n;
      count     <= count_n;
      mode      <= mode_n;
      dout      <= dout_n;
      ovf       <= ovf_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

`ifdef BIN_TO_XS3_SEQ_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par <= 1'b0;
    else        out_par <= ^dout_n;
  end
`endif

endmodule

// File: tb/tb_bin_to_xs3_seq.sv
// Scoreboard bench: a DIGITS=3 and a DIGITS=2 instance, expectations from a decimal model.
module tb_bin_to_xs3_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] bin_in;
  logic       mode_xs3;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a, busy_a;
  logic [11:0] dout_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b, busy_b;
  logic [7:0]  dout_b;
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
  logic        out_par_a, out_par_b;
`endif

  bin_to_xs3_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .bin_in(bin_in), .mode_xs3(mode_xs3), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .dout(dout_a), .ovf(ovf_a), .busy(busy_a)
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
    , .out_par(out_par_a)
`endif
  );

  bin_to_xs3_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .bin_in(bin_in), .mode_xs3(mode_xs3), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .dout(dout_b), .ovf(ovf_b), .busy(busy_b)
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
    , .out_par(out_par_b)
`endif
  );

  typedef struct packed {
    logic [11:0] dout;
    logic        ovf;
    logic        par;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Decimal reference: divide by ten, saturate to all nines, optional +3 per digit.
  function automatic exp_t model(input int unsigned v, input bit xs3, input int unsigned nd);
    exp_t        e;
    int unsigned lim, x;
    logic [3:0]  d;
    e   = '0;
    lim = 1;
    for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
    e.ovf = (v >= lim);
    x = v;
    for (int unsigned i = 0; i < nd; i++) begin
      d = e.ovf ? 4'd9 : 4'(x % 10);
      x = x / 10;
      if (xs3) d = d + 4'd3;
      e.dout[4*i +: 4] = d;
    end
    e.par = ^e.dout;
    return e;
  endfunction

  task automatic push_exp(input int unsigned v, input bit xs3, input int unsigned nd);
    sb.push_back(model(v, xs3, nd));
  endtask

  // Accept one operand, scramble inputs during CONV, wait (bounded) for out_valid.
  task automatic do_txn(input bit sel, input logic [7:0] v, input bit xs3,
                        output logic [11:0] od, output logic oovf, output logic opar,
                        output int lat, output bit to);
    @(posedge clk); #1;
    bin_in   = v;
    mode_xs3 = xs3;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 0;
    to  = 1'b0;
    while (!(sel ? out_valid_b : out_valid_a)) begin
      bin_in   = 8'($urandom);
      mode_xs3 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (lat > 40) begin
        to = 1'b1;
        break;
      end
    end
    od   = sel ? {4'h0, dout_b} : dout_a;
    oovf = sel ? ovf_b : ovf_a;
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
    opar = sel ? out_par_b : out_par_a;
`else
    opar = 1'b0;
`endif
  endtask

  task automatic release_out(input bit sel);
    if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0 ||
        dout_a !== 12'h000 || ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b dout=%h ovf=%b expected 1 0 0 000 0",
               in_ready_a, out_valid_a, busy_a, dout_a, ovf_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_convert;
    logic [7:0] vals [8]  = '{8'd255, 8'd255, 8'd0, 8'd9, 8'd1, 8'd37, 8'd128, 8'd199};
    bit         modes [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] od;
    logic        oovf, opar;
    int          lat;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      push_exp(vals[i], modes[i], 3);
      do_txn(1'b0, vals[i], modes[i], od, oovf, opar, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != 8) begin
        failures++;
        $display("FAIL convert_latency[%0d]: got %0d cycles (timeout=%0b) expected 8", vals[i], lat, to);
      end
      checks++;
      if (od !== e.dout || oovf !== e.ovf) begin
        failures++;
        $display("FAIL convert_dout[%0d mode %0d]: got %h ovf=%b expected %h ovf=%b",
                 vals[i], modes[i], od, oovf, e.dout, e.ovf);
      end
`ifdef BIN_TO_XS3_SEQ_PARITY_EN
      checks++;
      if (opar !== e.par) begin
        failures++;
        $display("FAIL parity[%0d]: got %b expected %b", vals[i], opar, e.par);
      end
`endif
      release_out(1'b0);
    end
  endtask

  task automatic test_ovf;
    logic [7:0] vals [5]  = '{8'd100, 8'd100, 8'd99, 8'd255, 8'd0};
    bit         modes [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] od;
    logic        oovf, opar;
    int          lat;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 5; i++) begin
      push_exp(vals[i], modes[i], 2);
      do_txn(1'b1, vals[i], modes[i], od, oovf, opar, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || od !== e.dout || oovf !== e.ovf) begin
        failures++;
        $display("FAIL ovf_dout[%0d mode %0d]: got %h ovf=%b timeout=%0b expected %h ovf=%b",
                 vals[i], modes[i], od, oovf, to, e.dout, e.ovf);
      end
      release_out(1'b1);
    end
  endtask

  task automatic test_back_pressure;
    logic [11:0] od;
    logic        oovf, opar;
    int          lat;
    bit          to;
    exp_t        e;
    push_exp(123, 1'b1, 3);
    do_txn(1'b0, 8'd123, 1'b1, od, oovf, opar, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || od !== e.dout) begin
      failures++;
      $display("FAIL bp_dout: got %h timeout=%0b expected %h", od, to, e.dout);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid_a = 1'b1;
      bin_in     = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || dout_a !== e.dout || ovf_a !== e.ovf) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b dout=%h ovf=%b expected 1 0 %h %b",
                 i, out_valid_a, in_ready_a, dout_a, ovf_a, e.dout, e.ovf);
      end
    end
    in_valid_a = 1'b0;
    release_out(1'b0);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || dout_a !== e.dout) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b dout=%h expected 0 1 %h",
               out_valid_a, in_ready_a, dout_a, e.dout);
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] od;
    logic        oovf, opar;
    int          lat;
    bit          to;
    exp_t        e;
    @(posedge clk); #1;
    bin_in     = 8'd200;
    mode_xs3   = 1'b1;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1 || dout_a !== 12'h000) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b dout=%h expected 0 0 1 000",
               out_valid_a, busy_a, in_ready_a, dout_a);
    end
    #1;
    rst_n = 1'b1;
    push_exp(37, 1'b0, 3);
    do_txn(1'b0, 8'd37, 1'b0, od, oovf, opar, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 8 || od !== e.dout || oovf !== e.ovf) begin
      failures++;
      $display("FAIL post_reset_conv: got %h ovf=%b lat=%0d timeout=%0b expected %h ovf=%b lat=8",
               od, oovf, lat, to, e.dout, e.ovf);
    end
    release_out(1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bin_in      = '0;
    mode_xs3    = 1'b0;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    test_reset();
    test_convert();
    test_ovf();
    test_back_pressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
